// File: rtl/victimcache_assoc_pkg.sv
// Shared types for the victim cache: bus widths, FSM states, entry layout and
// address/tag helpers. Line and address widths are fixed here so the entry
// struct and the bus interface agree; only the entry count is a module
// parameter.
package vc_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned TAG_W    = ADDR_W - OFFSET_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    RESP      = 2'd3
  } vc_state_t;

  typedef struct packed {
    logic  valid;
    logic  dirty;
    tag_t  tag;
    line_t data;
  } vc_entry_t;

  // Line tag of a byte address; offset bits are dropped.
  function automatic tag_t tag_of(input addr_t addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

  // Line-aligned byte address of a tag.
  function automatic addr_t addr_of(input tag_t tag);
    return {tag, OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/victimcache_assoc_if.sv
// Request/response bus of the victim cache.
//   L1 side : mem_address, vc_read, vc_write, mem_wdata, is_mem_wdata_dirty,
//             victim_address -> vc_rdata, vc_hit, vc_hit_dirty, vc_resp
//   mem side: pmem_address, pmem_wdata, pmem_write -> pmem_resp
// slave is the cache itself, master is the L1/memory environment.
interface victimcache_assoc_if;
  import vc_pkg::*;

  addr_t mem_address;
  logic  vc_read;
  logic  vc_write;
  line_t mem_wdata;
  logic  is_mem_wdata_dirty;
  addr_t victim_address;
  line_t vc_rdata;
  logic  vc_hit;
  logic  vc_hit_dirty;
  logic  vc_resp;
  addr_t pmem_address;
  line_t pmem_wdata;
  logic  pmem_write;
  logic  pmem_resp;

  modport slave (
    input  mem_address, vc_read, vc_write, mem_wdata, is_mem_wdata_dirty,
           victim_address, pmem_resp,
    output vc_rdata, vc_hit, vc_hit_dirty, vc_resp,
           pmem_address, pmem_wdata, pmem_write
  );

  modport master (
    output mem_address, vc_read, vc_write, mem_wdata, is_mem_wdata_dirty,
           victim_address, pmem_resp,
    input  vc_rdata, vc_hit, vc_hit_dirty, vc_resp,
           pmem_address, pmem_wdata, pmem_write
  );

endinterface

// File: rtl/victimcache_assoc_lru.sv
// Age-based LRU tracker for the victim cache entries.
//   clk, rst    : clock, synchronous active-low reset (all ages -> ENTRIES-1)
//   valid       : per-entry valid bits of the entry array
//   touch_en/idx: install into entry touch_idx this cycle
//   lru_idx     : valid entry holding the largest age (lowest index on ties)
module vc_lru #(
  parameter  int unsigned ENTRIES = 4,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENTRIES-1:0] valid,
  input  logic               touch_en,
  input  logic [IDX_W-1:0]   touch_idx,
  output logic [IDX_W-1:0]   lru_idx
);

  logic [IDX_W-1:0] age_q [ENTRIES];
  logic [IDX_W-1:0] age_d [ENTRIES];

  // Touched entry becomes youngest; valid entries younger than it age by one.
  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      age_d[i] = age_q[i];
    end
    if (touch_en) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (IDX_W'(i) == touch_idx) begin
          age_d[i] = '0;
        end else if (valid[i] && (age_q[i] < age_q[touch_idx])) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        age_q[i] <= IDX_W'(ENTRIES - 1);
      end
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  // Oldest valid entry. Normally the one aged ENTRIES-1; taking the maximum
  // keeps a defined victim even if invalidations left ages non-unique.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] best_age;
    found    = 1'b0;
    best_age = '0;
    lru_idx  = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (valid[i] && (!found || (age_q[i] > best_age))) begin
        found    = 1'b1;
        best_age = age_q[i];
        lru_idx  = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/victimcache_assoc.sv
// Fully associative victim cache between L1 and the cacheline adapter/L2.
// Holds ENTRIES evicted lines with dirty bits; read hits hand the line back to
// L1 and free the entry, inserts fill a matching/free/LRU slot, and a dirty
// LRU line displaced by an insert is written back before the new line lands.
//   clk, rst : clock, synchronous active-low reset
//   bus      : victimcache_assoc_if.slave (L1 request/response + writeback)
module victimcache_assoc
  import vc_pkg::*;
#(
  parameter int unsigned ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  victimcache_assoc_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  vc_state_t        state_q, state_d;
  vc_entry_t        entries_q [ENTRIES];
  vc_entry_t        entries_d [ENTRIES];

  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  tag_t             rd_tag_q, rd_tag_d;
  tag_t             vic_tag_q, vic_tag_d;
  line_t            wdata_q, wdata_d;
  logic             wdirty_q, wdirty_d;
  logic [IDX_W-1:0] inst_idx_q, inst_idx_d;

  line_t            vc_rdata_q, vc_rdata_d;
  logic             vc_hit_q, vc_hit_d;
  logic             vc_hit_dirty_q, vc_hit_dirty_d;
  logic             vc_resp_q, vc_resp_d;
  addr_t            pmem_address_q, pmem_address_d;
  line_t            pmem_wdata_q, pmem_wdata_d;
  logic             pmem_write_q, pmem_write_d;

  logic [ENTRIES-1:0] valid_vec;
  logic               hit, vic_match, free_any;
  logic [IDX_W-1:0]   hit_idx, vic_idx, free_idx, lru_idx;
  logic               touch_en;
  logic [IDX_W-1:0]   touch_idx;

  vc_lru #(.ENTRIES(ENTRIES)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid_vec),
    .touch_en  (touch_en),
    .touch_idx (touch_idx),
    .lru_idx   (lru_idx)
  );

  // Tag comparators; scanning downwards so the lowest index wins.
  always_comb begin
    hit       = 1'b0;
    vic_match = 1'b0;
    free_any  = 1'b0;
    hit_idx   = '0;
    vic_idx   = '0;
    free_idx  = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      valid_vec[i] = entries_q[i].valid;
      if (entries_q[i].valid && (entries_q[i].tag == rd_tag_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (entries_q[i].valid && (entries_q[i].tag == vic_tag_q)) begin
        vic_match = 1'b1;
        vic_idx   = IDX_W'(i);
      end
      if (!entries_q[i].valid) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Next-state, entry updates and response registers.
  always_comb begin
    logic [IDX_W-1:0] slot;
    logic             merge;
    logic             wb;

    state_d        = state_q;
    entries_d      = entries_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    rd_tag_d       = rd_tag_q;
    vic_tag_d      = vic_tag_q;
    wdata_d        = wdata_q;
    wdirty_d       = wdirty_q;
    inst_idx_d     = inst_idx_q;
    vc_rdata_d     = vc_rdata_q;
    vc_hit_d       = vc_hit_q;
    vc_hit_dirty_d = vc_hit_dirty_q;
    vc_resp_d      = 1'b0;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    pmem_write_d   = pmem_write_q;
    touch_en       = 1'b0;
    touch_idx      = inst_idx_q;
    slot           = '0;
    merge          = 1'b0;
    wb             = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.vc_read || bus.vc_write) begin
          rd_d      = bus.vc_read;
          wr_d      = bus.vc_write;
          rd_tag_d  = tag_of(bus.mem_address);
          vic_tag_d = tag_of(bus.victim_address);
          wdata_d   = bus.mem_wdata;
          wdirty_d  = bus.is_mem_wdata_dirty;
          state_d   = LOOKUP;
        end
      end

      LOOKUP: begin
        vc_hit_d       = rd_q && hit;
        vc_hit_dirty_d = rd_q && hit && entries_q[hit_idx].dirty;
        if (rd_q && hit) begin
          vc_rdata_d                = entries_q[hit_idx].data;
          entries_d[hit_idx].valid  = 1'b0;
        end

        if (wr_q) begin
          // Swap into the line just handed out, else merge, else free, else LRU.
          if (rd_q && hit) begin
            slot = hit_idx;
          end else if (vic_match) begin
            slot  = vic_idx;
            merge = 1'b1;
          end else if (free_any) begin
            slot = free_idx;
          end else begin
            slot = lru_idx;
          end
          wb = !(rd_q && hit) && entries_q[slot].valid && entries_q[slot].dirty &&
               (entries_q[slot].tag != vic_tag_q);
          inst_idx_d = slot;

          if (wb) begin
            pmem_address_d = addr_of(entries_q[slot].tag);
            pmem_wdata_d   = entries_q[slot].data;
            pmem_write_d   = 1'b1;
            state_d        = WRITEBACK;
          end else begin
            entries_d[slot].valid = 1'b1;
            entries_d[slot].dirty = merge ? (entries_q[slot].dirty | wdirty_q) : wdirty_q;
            entries_d[slot].tag   = vic_tag_q;
            entries_d[slot].data  = wdata_q;
            touch_en              = 1'b1;
            touch_idx             = slot;
            vc_resp_d             = 1'b1;
            state_d               = RESP;
          end
        end else begin
          vc_resp_d = 1'b1;
          state_d   = RESP;
        end
      end

      WRITEBACK: begin
        if (bus.pmem_resp) begin
          entries_d[inst_idx_q].valid = 1'b1;
          entries_d[inst_idx_q].dirty = wdirty_q;
          entries_d[inst_idx_q].tag   = vic_tag_q;
          entries_d[inst_idx_q].data  = wdata_q;
          touch_en                    = 1'b1;
          touch_idx                   = inst_idx_q;
          pmem_write_d                = 1'b0;
          vc_resp_d                   = 1'b1;
          state_d                     = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries_q[i] <= '0;
      end
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      rd_tag_q       <= '0;
      vic_tag_q      <= '0;
      wdata_q        <= '0;
      wdirty_q       <= 1'b0;
      inst_idx_q     <= '0;
      vc_rdata_q     <= '0;
      vc_hit_q       <= 1'b0;
      vc_hit_dirty_q <= 1'b0;
      vc_resp_q      <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      pmem_write_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries_q[i] <= entries_d[i];
      end
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      rd_tag_q       <= rd_tag_d;
      vic_tag_q      <= vic_tag_d;
      wdata_q        <= wdata_d;
      wdirty_q       <= wdirty_d;
      inst_idx_q     <= inst_idx_d;
      vc_rdata_q     <= vc_rdata_d;
      vc_hit_q       <= vc_hit_d;
      vc_hit_dirty_q <= vc_hit_dirty_d;
      vc_resp_q      <= vc_resp_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      pmem_write_q   <= pmem_write_d;
    end
  end

  assign bus.vc_rdata     = vc_rdata_q;
  assign bus.vc_hit       = vc_hit_q;
  assign bus.vc_hit_dirty = vc_hit_dirty_q;
  assign bus.vc_resp      = vc_resp_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
  assign bus.pmem_write   = pmem_write_q;

endmodule
